// File: rtl/tri_raster_sequencer_pkg.sv
// Shared types and constants for the triangle raster sequencer.
// Coordinates are unsigned fixed point; pixel coordinates are INT_W-bit integers.
package tri_raster_sequencer_pkg;

  localparam int INT_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WALK,
    FIN
  } state_t;

  // Rounding adds the weight of the highest fractional bit (round half up).
  function automatic int rnd_pos(input int frac_bits);
    return frac_bits - 1;
  endfunction

endpackage

// File: rtl/tri_bbox_calc.sv
// One axis of the triangle bounding box: min/max of three fixed-point values,
// rounded to integer, max clipped to LIMIT, empty when min exceeds clipped max.
module tri_bbox_calc
  import tri_raster_sequencer_pkg::*;
#(
  parameter int FRAC_BITS = 6,
  parameter int LIMIT     = 639
) (
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic [15:0]      c,
  output logic [INT_W-1:0] vmin,
  output logic [INT_W-1:0] vmax,
  output logic             empty
);

  localparam int RB = rnd_pos(FRAC_BITS);

  logic [15:0]    mn, mx;
  logic [16:0]    smin, smax;
  logic [INT_W:0] rmin, rmax, lim, cmax;

  always_comb begin
    mn = a;
    mx = a;
    if (b < mn) mn = b;
    if (c < mn) mn = c;
    if (b > mx) mx = b;
    if (c > mx) mx = c;
    // 17-bit sum keeps 0xFFFF from wrapping; the result needs INT_W+1 bits.
    smin = ({1'b0, mn} + 17'(1 << RB)) >> FRAC_BITS;
    smax = ({1'b0, mx} + 17'(1 << RB)) >> FRAC_BITS;
    rmin = (INT_W+1)'(smin);
    rmax = (INT_W+1)'(smax);
    lim  = (INT_W+1)'(LIMIT);
    cmax = (rmax > lim) ? lim : rmax;
    vmin  = rmin[INT_W-1:0];
    vmax  = cmax[INT_W-1:0];
    empty = (rmin > cmax);
  end

endmodule

// File: rtl/tri_raster_sequencer.sv
// Accepts one triangle, registers its clipped bounding box, then emits every
// pixel of the box in raster order over a valid/ready handshake.
module tri_raster_sequencer
  import tri_raster_sequencer_pkg::*;
#(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int FRAC_BITS = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TRI_VALID,
  output logic             TRI_READY,
  input  logic [15:0]      V0X,
  input  logic [15:0]      V1X,
  input  logic [15:0]      V2X,
  input  logic [15:0]      V0Y,
  input  logic [15:0]      V1Y,
  input  logic [15:0]      V2Y,
  output logic             PIX_VALID,
  input  logic             PIX_READY,
  output logic [INT_W-1:0] PIX_X,
  output logic [INT_W-1:0] PIX_Y,
  output logic             PIX_LAST,
  output logic [INT_W-1:0] XMIN,
  output logic [INT_W-1:0] XMAX,
  output logic [INT_W-1:0] YMIN,
  output logic [INT_W-1:0] YMAX,
  output logic             BUSY,
  output logic             DONE
);

  state_t           state, state_nxt;
  logic [15:0]      vx0, vx1, vx2, vy0, vy1, vy2;
  logic [INT_W-1:0] bx_min, bx_max, by_min, by_max;
  logic             x_empty, y_empty;
  logic             box_empty;

  tri_bbox_calc #(.FRAC_BITS(FRAC_BITS), .LIMIT(H_RES-1)) u_bbox_x (
    .a(vx0), .b(vx1), .c(vx2), .vmin(bx_min), .vmax(bx_max), .empty(x_empty)
  );

  tri_bbox_calc #(.FRAC_BITS(FRAC_BITS), .LIMIT(V_RES-1)) u_bbox_y (
    .a(vy0), .b(vy1), .c(vy2), .vmin(by_min), .vmax(by_max), .empty(y_empty)
  );

  assign box_empty = x_empty | y_empty;
  // Gated by WALK so the all-zero reset registers never read as a last pixel.
  assign PIX_LAST  = (state == WALK) && (PIX_X == XMAX) && (PIX_Y == YMAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    TRI_READY = 1'b0;
    PIX_VALID = 1'b0;
    BUSY      = 1'b1;
    DONE      = 1'b0;
    case (state)
      IDLE: begin
        TRI_READY = ~RST;
        BUSY      = 1'b0;
        if (TRI_VALID && !RST) state_nxt = LOAD;
      end
      LOAD: state_nxt = box_empty ? FIN : WALK;
      WALK: begin
        PIX_VALID = 1'b1;
        if (PIX_READY && PIX_LAST) state_nxt = FIN;
      end
      FIN: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      {vx0, vx1, vx2, vy0, vy1, vy2} <= '0;
      {XMIN, XMAX, YMIN, YMAX}       <= '0;
      PIX_X <= '0;
      PIX_Y <= '0;
    end else begin
      case (state)
        IDLE: if (TRI_VALID) begin
          vx0 <= V0X; vx1 <= V1X; vx2 <= V2X;
          vy0 <= V0Y; vy1 <= V1Y; vy2 <= V2Y;
        end
        LOAD: begin
          XMIN <= bx_min;
          XMAX <= bx_max;
          YMIN <= by_min;
          YMAX <= by_max;
          if (!box_empty) begin
            PIX_X <= bx_min;
            PIX_Y <= by_min;
          end
        end
        // The last pixel holds its coordinate; there is nothing after it to walk to.
        WALK: if (PIX_READY && !PIX_LAST) begin
          if (PIX_X < XMAX) begin
            PIX_X <= PIX_X + 1'b1;
          end else begin
            PIX_X <= XMIN;
            PIX_Y <= PIX_Y + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_raster_sequencer.sv
// Directed bench for tri_raster_sequencer: hand-computed boxes and pixel
// sequences, outputs sampled on the falling edge.
module tb_tri_raster_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tri_valid = 1'b0;
  logic [15:0] v0x = '0, v1x = '0, v2x = '0, v0y = '0, v1y = '0, v2y = '0;
  logic        pix_ready = 1'b1;
  logic        tri_ready, pix_valid, pix_last, busy, done;
  logic [9:0]  pix_x, pix_y, xmin, xmax, ymin, ymax;

  int n_chk = 0;
  int n_fail = 0;
  logic [9:0] exp_x[$];
  logic [9:0] exp_y[$];

  tri_raster_sequencer #(.H_RES(640), .V_RES(480), .FRAC_BITS(6)) dut (
    .CLK(clk), .RST(rst), .TRI_VALID(tri_valid), .TRI_READY(tri_ready),
    .V0X(v0x), .V1X(v1x), .V2X(v2x), .V0Y(v0y), .V1Y(v1y), .V2Y(v2y),
    .PIX_VALID(pix_valid), .PIX_READY(pix_ready), .PIX_X(pix_x), .PIX_Y(pix_y),
    .PIX_LAST(pix_last), .XMIN(xmin), .XMAX(xmax), .YMIN(ymin), .YMAX(ymax),
    .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic fill_box(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        exp_x.push_back(10'(x));
        exp_y.push_back(10'(y));
      end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept (LOAD).
  task automatic send_tri(input logic [15:0] x0, x1, x2, y0, y1, y2);
    n_chk++;
    if (tri_ready !== 1'b1) begin
      n_fail++; $display("FAIL send_ready: TRI_READY=%b want 1", tri_ready);
    end
    tri_valid = 1'b1;
    v0x = x0; v1x = x1; v2x = x2; v0y = y0; v1y = y1; v2y = y2;
    @(negedge clk);
    tri_valid = 1'b0;
    {v0x, v1x, v2x, v0y, v1y, v2y} = {6{16'h1234}};
    n_chk++;
    if ({busy, pix_valid, tri_ready} !== 3'b100) begin
      n_fail++; $display("FAIL load_state: busy,valid,ready=%b want 100", {busy, pix_valid, tri_ready});
    end
  endtask

  // Consumes exp_x/exp_y in order; bp selects ready pattern 1,0,0 repeating.
  task automatic walk(input string name, input bit bp);
    int idx = 0;
    int cyc = 0;
    int n = exp_x.size();
    while (idx < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      n_chk++;
      if (pix_valid !== 1'b1 || pix_x !== exp_x[idx] || pix_y !== exp_y[idx] ||
          pix_last !== (idx == n-1)) begin
        n_fail++;
        $display("FAIL %s pix%0d: got v=%b (%0d,%0d) last=%b want v=1 (%0d,%0d) last=%b",
                 name, idx, pix_valid, pix_x, pix_y, pix_last, exp_x[idx], exp_y[idx], idx == n-1);
      end
      if (pix_valid !== 1'b1) break;
      pix_ready = bp ? (cyc % 3 == 1) : 1'b1;
      if (pix_ready) idx++;
    end
    n_chk++;
    if (idx != n) begin
      n_fail++; $display("FAIL %s count: got %0d pixels want %0d", name, idx, n);
    end
    pix_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({done, pix_valid, busy} !== 3'b101) begin
      n_fail++; $display("FAIL %s fin: done,valid,busy=%b want 101", name, {done, pix_valid, busy});
    end
    @(negedge clk);
    n_chk++;
    if ({done, busy, tri_ready} !== 3'b001) begin
      n_fail++; $display("FAIL %s idle: done,busy,ready=%b want 001", name, {done, busy, tri_ready});
    end
    exp_x.delete();
    exp_y.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    n_chk++;
    if ({tri_ready, busy, pix_valid, pix_last, done, pix_x, pix_y, xmin, xmax, ymin, ymax} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: ready=%b busy=%b valid=%b last=%b done=%b want all 0",
                         tri_ready, busy, pix_valid, pix_last, done);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if ({tri_ready, busy} !== 2'b10) begin
      n_fail++; $display("FAIL reset_release: ready,busy=%b want 10", {tri_ready, busy});
    end
    @(negedge clk);
  endtask

  task automatic test_basic;
    send_tri(16'h0040, 16'h00C0, 16'h0080, 16'h0040, 16'h0040, 16'h0080);
    fill_box(1, 3, 1, 2);
    walk("basic", 1'b0);
    n_chk++;
    if ({xmin, xmax, ymin, ymax} !== {10'd1, 10'd3, 10'd1, 10'd2}) begin
      n_fail++; $display("FAIL basic_box: got %0d..%0d x %0d..%0d want 1..3 x 1..2", xmin, xmax, ymin, ymax);
    end
  endtask

  task automatic test_rounding;
    send_tri(16'h0060, 16'h0060, 16'h0060, 16'h0040, 16'h0040, 16'h0040);
    fill_box(2, 2, 1, 1);
    walk("round_up", 1'b0);
    n_chk++;
    if ({xmin, xmax} !== {10'd2, 10'd2}) begin
      n_fail++; $display("FAIL round_up_box: got x %0d..%0d want 2..2", xmin, xmax);
    end
    send_tri(16'h005F, 16'h005F, 16'h005F, 16'h005F, 16'h0060, 16'h0040);
    fill_box(1, 1, 1, 2);
    walk("round_down", 1'b0);
    n_chk++;
    if ({xmin, xmax, ymin, ymax} !== {10'd1, 10'd1, 10'd1, 10'd2}) begin
      n_fail++; $display("FAIL round_down_box: got %0d..%0d x %0d..%0d want 1..1 x 1..2", xmin, xmax, ymin, ymax);
    end
  endtask

  task automatic test_backpressure;
    send_tri(16'h0040, 16'h00C0, 16'h0080, 16'h0040, 16'h0040, 16'h0080);
    fill_box(1, 3, 1, 2);
    walk("backpressure", 1'b1);
  endtask

  task automatic test_clip;
    send_tri(16'h0040, 16'hFFFF, 16'h0040, 16'h0040, 16'h0040, 16'h0040);
    fill_box(1, 639, 1, 1);
    walk("clip", 1'b0);
    n_chk++;
    if ({xmin, xmax} !== {10'd1, 10'd639}) begin
      n_fail++; $display("FAIL clip_box: got x %0d..%0d want 1..639", xmin, xmax);
    end
  endtask

  task automatic test_empty;
    send_tri(16'hA000, 16'hA000, 16'hA000, 16'h0040, 16'h0040, 16'h0040);
    @(negedge clk);
    n_chk++;
    if ({done, pix_valid, busy} !== 3'b101) begin
      n_fail++; $display("FAIL empty_fin: done,valid,busy=%b want 101", {done, pix_valid, busy});
    end
    n_chk++;
    if (xmax !== 10'd639) begin
      n_fail++; $display("FAIL empty_xmax: got %0d want 639", xmax);
    end
    @(negedge clk);
    n_chk++;
    if ({done, pix_valid, tri_ready} !== 3'b001) begin
      n_fail++; $display("FAIL empty_idle: done,valid,ready=%b want 001", {done, pix_valid, tri_ready});
    end
  endtask

  task automatic test_degenerate;
    send_tri(16'h0140, 16'h0140, 16'h0140, 16'h0140, 16'h0140, 16'h0140);
    fill_box(5, 5, 5, 5);
    walk("degenerate", 1'b0);
  endtask

  task automatic test_reset_mid_walk;
    logic [9:0] ex[3] = '{10'd1, 10'd2, 10'd3};
    send_tri(16'h0040, 16'h00C0, 16'h0080, 16'h0040, 16'h0040, 16'h0080);
    pix_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if ({pix_valid, pix_x, pix_y} !== {1'b1, ex[i], 10'd1}) begin
        n_fail++; $display("FAIL midwalk_pix%0d: got v=%b (%0d,%0d) want v=1 (%0d,1)", i, pix_valid, pix_x, pix_y, ex[i]);
      end
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({tri_ready, busy, pix_valid, pix_last, done, pix_x, pix_y, xmin, xmax, ymin, ymax} !== '0) begin
      n_fail++; $display("FAIL midwalk_reset: ready=%b busy=%b valid=%b x=%0d y=%0d xmax=%0d want all 0",
                         tri_ready, busy, pix_valid, pix_x, pix_y, xmax);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if ({tri_ready, busy} !== 2'b10) begin
      n_fail++; $display("FAIL midwalk_release: ready,busy=%b want 10", {tri_ready, busy});
    end
    @(negedge clk);
    send_tri(16'h0080, 16'h0100, 16'h0080, 16'h00C0, 16'h00C0, 16'h00C0);
    fill_box(2, 4, 3, 3);
    walk("after_reset", 1'b0);
    n_chk++;
    if ({xmin, xmax, ymin, ymax} !== {10'd2, 10'd4, 10'd3, 10'd3}) begin
      n_fail++; $display("FAIL after_reset_box: got %0d..%0d x %0d..%0d want 2..4 x 3..3", xmin, xmax, ymin, ymax);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_backpressure();
    test_clip();
    test_empty();
    test_degenerate();
    test_reset_mid_walk();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
